// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg -- shared definitions for the NAND-only logic sequencer.
//   Opcode encodings, FSM state encoding, per-opcode step counts and small
//   decode helpers used by nand_seq.
package nand_seq_pkg;

  // Opcode encodings (in_op)
  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;

  // Number of NAND bank evaluations each opcode needs
  localparam int unsigned STEPS_NAND = 1;
  localparam int unsigned STEPS_AND  = 2;
  localparam int unsigned STEPS_OR   = 3;
  localparam int unsigned STEPS_XOR  = 4;
  localparam int unsigned STEPS_NOT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Remaining-steps down-counter; the final step is the one taken at zero.
  typedef logic [1:0] step_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_NAND, OP_AND, OP_OR, OP_XOR, OP_NOT: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

  // Down-counter load value: step count minus one (0 for illegal codes).
  function automatic step_t first_step(input logic [2:0] op);
    case (op)
      OP_NAND: first_step = step_t'(STEPS_NAND - 1);
      OP_AND:  first_step = step_t'(STEPS_AND - 1);
      OP_OR:   first_step = step_t'(STEPS_OR - 1);
      OP_XOR:  first_step = step_t'(STEPS_XOR - 1);
      OP_NOT:  first_step = step_t'(STEPS_NOT - 1);
      default: first_step = '0;
    endcase
  endfunction

endpackage

// File: rtl/nand_seq_bank.sv
// nand_bank -- WIDTH-wide bank of two-input NAND gates, one primitive per bit.
//   x, y : operands
//   z    : bitwise ~(x & y)
module nand_bank #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output wire  [WIDTH-1:0] z
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand u_nand (z[i], x[i], y[i]);
  end

endmodule

// File: rtl/nand_seq.sv
// nand_seq -- evaluates NAND/AND/OR/XOR/NOT by sequencing one shared NAND bank,
// one bank evaluation per cycle, with valid/ready handshakes on both sides.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake (in_ready only while IDLE)
//   in_op, in_a, in_b   : opcode and operands, captured at acceptance
//   out_valid/out_ready : result handshake, result held in DONE
//   out_data, out_err   : result; out_err marks an illegal opcode
//   perf_cnt            : saturating count of NAND bank evaluations
//
// Build option: define NAND_SEQ_PERF_EN to enable the perf counter; otherwise
// perf_cnt is tied to zero.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// EVAL  | one NAND bank evaluation per cycle, remaining-steps counter runs down
// DONE  | result presented, waiting for out_ready
import nand_seq_pkg::*;

module nand_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [15:0]      perf_cnt
);

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] w_q, p_q, q_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  step_t            left_q;

  logic [WIDTH-1:0] bank_x, bank_y;
  wire  [WIDTH-1:0] bank_z;

  logic accept;
  logic eval;
  logic wr_w, wr_p, wr_q, wr_out;
  logic fin_illegal;

  nand_bank #(.WIDTH(WIDTH)) u_bank (
    .x (bank_x),
    .y (bank_y),
    .z (bank_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand routing follows the remaining-steps counter: the highest count is
  // the first step of the sequence, zero is the final step that yields the result.
  always_comb begin
    state_nxt   = state;
    bank_x      = '0;
    bank_y      = '0;
    accept      = 1'b0;
    eval        = 1'b0;
    wr_w        = 1'b0;
    wr_p        = 1'b0;
    wr_q        = 1'b0;
    wr_out      = 1'b0;
    fin_illegal = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        if (!op_legal(op_q)) begin
          fin_illegal = 1'b1;
          state_nxt   = DONE;
        end else begin
          eval = 1'b1;
          case (op_q)
            OP_NAND: begin
              bank_x = a_q;
              bank_y = b_q;
            end
            OP_NOT: begin
              bank_x = a_q;
              bank_y = a_q;
            end
            OP_AND: begin
              if (left_q == 2'd1) begin
                bank_x = a_q;
                bank_y = b_q;
                wr_w   = 1'b1;
              end else begin
                bank_x = w_q;
                bank_y = w_q;
              end
            end
            OP_OR: begin
              case (left_q)
                2'd2: begin
                  bank_x = a_q;
                  bank_y = a_q;
                  wr_w   = 1'b1;
                end
                2'd1: begin
                  bank_x = b_q;
                  bank_y = b_q;
                  wr_p   = 1'b1;
                end
                default: begin
                  bank_x = w_q;
                  bank_y = p_q;
                end
              endcase
            end
            OP_XOR: begin
              case (left_q)
                2'd3: begin
                  bank_x = a_q;
                  bank_y = b_q;
                  wr_w   = 1'b1;
                end
                2'd2: begin
                  bank_x = a_q;
                  bank_y = w_q;
                  wr_p   = 1'b1;
                end
                2'd1: begin
                  bank_x = b_q;
                  bank_y = w_q;
                  wr_q   = 1'b1;
                end
                default: begin
                  bank_x = p_q;
                  bank_y = q_q;
                end
              endcase
            end
            default: ;
          endcase
          if (left_q == '0) begin
            wr_out    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      w_q    <= '0;
      p_q    <= '0;
      q_q    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      left_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= in_op;
        a_q    <= in_a;
        b_q    <= in_b;
        left_q <= first_step(in_op);
      end else if (eval && (left_q != '0)) begin
        left_q <= left_q - 2'd1;
      end
      if (wr_w) w_q <= bank_z;
      if (wr_p) p_q <= bank_z;
      if (wr_q) q_q <= bank_z;
      if (wr_out) begin
        data_q <= bank_z;
        err_q  <= 1'b0;
      end else if (fin_illegal) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data_q;
  assign out_err   = err_q;

`ifdef NAND_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           perf_q <= '0;
    else if (eval && (perf_q != 16'hFFFF)) perf_q <= perf_q + 16'd1;
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule
